// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use detection, branch
// resolution from EX/MEM, multi-cycle data-memory freeze and perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_Branch,
  input  logic             mem_Zero,
  input  logic             mem_is_greater,
  input  logic [3:0]       mem_funct,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_src,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned    WCW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic timeout_hit;
  logic mem_stall;
  logic br_taken;
  logic load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  // Hazard detection
  always_comb begin
    dmem_req = mem_MemRead | mem_MemWrite;
    // An ack on the final wait cycle wins over the timeout.
    timeout_hit = (state_q == MEM_WAIT) && dmem_req && !dmem_ack && (wcnt_q == WLAST);
    mem_stall   = dmem_req && !dmem_ack && !timeout_hit;

    br_taken = 1'b0;
    if (mem_Branch) begin
      casez (mem_funct)
        4'b?000: br_taken = mem_Zero;
        4'b?001: br_taken = !mem_Zero;
        4'b?100: br_taken = !mem_is_greater && !mem_Zero;
        4'b?101: br_taken = mem_is_greater || mem_Zero;
        default: br_taken = 1'b0;
      endcase
    end

    load_use = ex_MemRead && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // Pipeline register control, in priority order
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_src       = 1'b0;
    if (mem_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (br_taken) begin
      pc_src       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // Next state, wait counter, sticky error and counters
  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;
    timeout_d = timeout_q | timeout_hit;
    stall_d   = stall_q;
    flush_d   = flush_q;

    unique case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        // Leaves on ack, on timeout, or if the request is withdrawn.
        if (mem_stall) wcnt_d = wcnt_q + 1'b1;
        else           state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if ((mem_stall || (load_use && !br_taken)) && (stall_q != '1))
      stall_d = stall_q + 1'b1;
    if (!mem_stall && br_taken && (flush_q != '1))
      flush_d = flush_q + 1'b1;
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios against fixed
// expectations plus randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  // {dmem_req, pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, pc_src}
  localparam logic [8:0] NORMAL  = 9'b0_1111_000_0;
  localparam logic [8:0] STALL   = 9'b1_0000_000_0;
  localparam logic [8:0] ADV     = 9'b1_1111_000_0;
  localparam logic [8:0] BRANCH  = 9'b0_1111_111_1;
  localparam logic [8:0] LOADUSE = 9'b0_0011_010_0;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_MemRead, mem_Branch, mem_Zero, mem_is_greater;
  logic [3:0] mem_funct;
  logic mem_MemRead, mem_MemWrite, dmem_ack;
  logic dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, pc_src, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;
  logic [8:0] ctl;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .mem_Branch(mem_Branch), .mem_Zero(mem_Zero), .mem_is_greater(mem_is_greater),
    .mem_funct(mem_funct), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .pc_src(pc_src), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign ctl = {dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, ex_mem_flush, pc_src};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit m_wait, m_to;
  int m_wc, m_sc, m_fc;
  bit e_stall, e_br, e_lu, e_to;
  logic [8:0] e_ctl;

  task automatic model_reset();
    m_wait = 0; m_to = 0; m_wc = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_eval();
    bit req;
    int f3;
    req = mem_MemRead | mem_MemWrite;
    f3  = int'(mem_funct[2:0]);
    e_to    = m_wait && req && !dmem_ack && (m_wc == MT - 1);
    e_stall = req && !dmem_ack && !e_to;
    e_br = 0;
    if (mem_Branch) begin
      if (f3 == 0)      e_br = mem_Zero;
      else if (f3 == 1) e_br = !mem_Zero;
      else if (f3 == 4) e_br = !mem_is_greater && !mem_Zero;
      else if (f3 == 5) e_br = mem_is_greater || mem_Zero;
    end
    e_lu = ex_MemRead && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (e_stall)   e_ctl = STALL;
    else if (e_br) e_ctl = BRANCH;
    else if (e_lu) e_ctl = LOADUSE;
    else           e_ctl = NORMAL;
    e_ctl[8] = req;
  endtask

  task automatic model_clock();
    if (e_stall || (e_lu && !e_br)) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    if (!e_stall && e_br)           m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    if (e_to) m_to = 1;
    if (!m_wait) begin
      if (e_stall) begin m_wait = 1; m_wc = 0; end
    end else if (e_stall) m_wc++;
    else begin m_wait = 0; m_wc = 0; end
  endtask

  // ---------------- helpers ----------------
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_MemRead = 0;
    mem_Branch = 0; mem_Zero = 0; mem_is_greater = 0; mem_funct = 0;
    mem_MemRead = 0; mem_MemWrite = 0; dmem_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, NORMAL); end
    checks++; if (stall_count !== 0 || flush_count !== 0) begin errors++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", stall_count, flush_count); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout); end
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_MemRead = 1; ex_rd = 5; id_rs1 = 3; id_rs2 = 5;
    #3;
    checks++; if (ctl !== LOADUSE) begin errors++; $display("FAIL lu_rs2_ctl: got %b expected %b", ctl, LOADUSE); end
    step();
    checks++; if (stall_count !== 1) begin errors++; $display("FAIL lu_count: got %0d expected 1", stall_count); end
    ex_rd = 7; id_rs1 = 7; id_rs2 = 1;
    #3;
    checks++; if (ctl !== LOADUSE) begin errors++; $display("FAIL lu_rs1_ctl: got %b expected %b", ctl, LOADUSE); end
    step();
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    #3;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL lu_rd0_ctl: got %b expected %b", ctl, NORMAL); end
    step();
    checks++; if (stall_count !== 2) begin errors++; $display("FAIL lu_rd0_count: got %0d expected 2", stall_count); end
  endtask

  task automatic test_branch();
    do_reset();
    mem_Branch = 1; mem_funct = 4'b0001; mem_Zero = 0;
    #3;
    checks++; if (ctl !== BRANCH) begin errors++; $display("FAIL bne_taken: got %b expected %b", ctl, BRANCH); end
    step();
    checks++; if (flush_count !== 1) begin errors++; $display("FAIL bne_count: got %0d expected 1", flush_count); end
    mem_Zero = 1;
    #3;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL bne_not_taken: got %b expected %b", ctl, NORMAL); end
    step();
    mem_funct = 4'b0100; mem_Zero = 0; mem_is_greater = 0;
    #3;
    checks++; if (ctl !== BRANCH) begin errors++; $display("FAIL blt_taken: got %b expected %b", ctl, BRANCH); end
    step();
    mem_funct = 4'b0101;
    #3;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL bge_not_taken: got %b expected %b", ctl, NORMAL); end
    step();
    mem_funct = 4'b0010; mem_Zero = 1;
    #3;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL f3_other: got %b expected %b", ctl, NORMAL); end
    step();
    checks++; if (flush_count !== 2) begin errors++; $display("FAIL br_count_total: got %0d expected 2", flush_count); end
  endtask

  task automatic test_mem3();
    do_reset();
    mem_MemRead = 1; dmem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++; if (ctl !== STALL) begin errors++; $display("FAIL mem3_stall[%0d]: got %b expected %b", i, ctl, STALL); end
      step();
    end
    dmem_ack = 1;
    #3;
    checks++; if (ctl !== ADV) begin errors++; $display("FAIL mem3_advance: got %b expected %b", ctl, ADV); end
    checks++; if (stall_count !== 3) begin errors++; $display("FAIL mem3_count: got %0d expected 3", stall_count); end
    step();
    idle();
    #3;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL mem3_after: got %b expected %b", ctl, NORMAL); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    mem_MemWrite = 1; dmem_ack = 1;
    #3;
    checks++; if (ctl !== ADV) begin errors++; $display("FAIL zw_ctl: got %b expected %b", ctl, ADV); end
    step();
    idle();
    #3;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL zw_after: got %b expected %b", ctl, NORMAL); end
    step();
    checks++; if (stall_count !== 0) begin errors++; $display("FAIL zw_count: got %0d expected 0", stall_count); end
  endtask

  // Request held without ack; leaves mem_timeout set for test_reset_mid_wait.
  task automatic test_timeout();
    do_reset();
    mem_MemRead = 1; dmem_ack = 0;
    for (int i = 0; i < MT; i++) begin
      #3;
      checks++; if (ctl !== STALL) begin errors++; $display("FAIL to_stall[%0d]: got %b expected %b", i, ctl, STALL); end
      step();
    end
    #3;
    checks++; if (ctl !== ADV) begin errors++; $display("FAIL to_advance: got %b expected %b", ctl, ADV); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", mem_timeout); end
    step();
    idle();
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", mem_timeout); end
    repeat (3) step();
    checks++; if (mem_timeout !== 1'b1 || stall_count !== MT) begin errors++;
      $display("FAIL to_sticky: got flag %b count %0d expected 1 %0d", mem_timeout, stall_count, MT); end
  endtask

  task automatic test_reset_mid_wait();
    mem_MemRead = 1; dmem_ack = 0;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_timeout !== 1'b0 || stall_count !== 0 || flush_count !== 0) begin errors++;
      $display("FAIL rst_mid_wait: got flag %b counts %0d/%0d expected 0 0/0", mem_timeout, stall_count, flush_count); end
    idle();
    step();
    rst_n = 1'b1;
    #3;
    checks++; if (ctl !== NORMAL) begin errors++; $display("FAIL rst_mid_wait_ctl: got %b expected %b", ctl, NORMAL); end
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    mem_MemWrite = 1; dmem_ack = 0;
    repeat (MT) step();
    dmem_ack = 1;
    #3;
    checks++; if (ctl !== ADV) begin errors++; $display("FAIL ack_edge_ctl: got %b expected %b", ctl, ADV); end
    step();
    idle();
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL ack_edge_flag: got %b expected 0", mem_timeout); end
  endtask

  task automatic test_priority();
    do_reset();
    ex_MemRead = 1; ex_rd = 9; id_rs1 = 9;
    mem_Branch = 1; mem_funct = 4'b0000; mem_Zero = 1;
    #3;
    checks++; if (ctl !== BRANCH) begin errors++; $display("FAIL prio_br_lu: got %b expected %b", ctl, BRANCH); end
    step();
    checks++; if (stall_count !== 0 || flush_count !== 1) begin errors++;
      $display("FAIL prio_counts: got %0d/%0d expected 0/1", stall_count, flush_count); end
    mem_MemRead = 1;
    #3;
    checks++; if (ctl !== STALL) begin errors++; $display("FAIL prio_mem_first: got %b expected %b", ctl, STALL); end
    step();
    checks++; if (stall_count !== 1 || flush_count !== 1) begin errors++;
      $display("FAIL prio_mem_counts: got %0d/%0d expected 1/1", stall_count, flush_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_MemRead = 1; ex_rd = 2; id_rs1 = 2;
    repeat (CMAX + 3) step();
    checks++; if (stall_count !== CMAX) begin errors++; $display("FAIL sat_stall: got %0d expected %0d", stall_count, CMAX); end
    idle();
    mem_Branch = 1; mem_funct = 4'b0001;
    repeat (CMAX + 3) step();
    checks++; if (flush_count !== CMAX) begin errors++; $display("FAIL sat_flush: got %0d expected %0d", flush_count, CMAX); end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      ex_MemRead     = 1'($urandom_range(0, 1));
      mem_Branch     = 1'($urandom_range(0, 1));
      mem_Zero       = 1'($urandom_range(0, 1));
      mem_is_greater = 1'($urandom_range(0, 1));
      mem_funct      = 4'($urandom);
      if (!m_wait) begin
        mem_MemRead  = ($urandom_range(0, 3) == 0);
        mem_MemWrite = ($urandom_range(0, 3) == 0);
      end
      dmem_ack = ($urandom_range(0, 4) == 0);
      #3;
      model_eval();
      checks++; if (ctl !== e_ctl) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", n, ctl, e_ctl); end
      model_clock();
      step();
      checks++; if (stall_count !== CW'(m_sc) || flush_count !== CW'(m_fc) || mem_timeout !== m_to) begin errors++;
        $display("FAIL rnd_state[%0d]: got %0d/%0d/%b expected %0d/%0d/%b", n,
                 stall_count, flush_count, mem_timeout, m_sc, m_fc, m_to); end
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_load_use();
    test_branch();
    test_mem3();
    test_zero_wait();
    test_timeout();
    test_reset_mid_wait();
    test_ack_at_timeout();
    test_priority();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
